psum_accum_sched: RTL and testbench

Shared-accumulator scheduler for the SpMV partial-sum stage. Arbitrates up to N multiplier lanes, each presenting a product tagged with an output-row index, onto one combinational single-precision `fp_adder`. Adds each accepted product into a per-row accumulator bank. On flush, drains the bank row by row over a valid/ready output port to the vector write-back stage.

---
 rtl/psum_accum_sched_pkg.sv | 5 +
 rtl/fp_adder.sv | 35 +++
 rtl/psum_accum_sched_rr_arbiter.sv | 22 ++
 rtl/psum_accum_sched.sv | 99 +++++++++
 tb/tb_psum_accum_sched.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/psum_accum_sched_pkg.sv
// psum_accum_sched_pkg: shared FSM state encoding and FP constants for the partial-sum scheduler.
package psum_accum_sched_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
endpackage

// File: rtl/fp_adder.sv
// fp_adder: combinational single-precision adder; truncating, denormals flushed to zero, no NaN/Inf handling.
module fp_adder
  import psum_accum_sched_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        a_big;
  logic [31:0] hi, lo;
  logic [7:0]  eh, el, ed;
  logic [23:0] mh, ml, ms, dif, dn;
  logic [24:0] sum;
  logic [4:0]  lz;
  always_comb begin
    a_big = a[30:0] >= b[30:0];
    hi = a_big ? a : b;
    lo = a_big ? b : a;
    eh = hi[30:23];
    el = lo[30:23];
    mh = eh == 8'd0 ? '0 : {1'b1, hi[22:0]};
    ml = el == 8'd0 ? '0 : {1'b1, lo[22:0]};
    ed = eh - el;
    ms = ed > 8'd23 ? '0 : ml >> ed;
    sum = {1'b0, mh} + {1'b0, ms};
    dif = mh - ms;
    lz = 5'd24;
    for (int k = 0; k < 24; k++) if (dif[k]) lz = 5'(23 - k);
    dn = dif << lz;
    y = FP_ZERO;
    if (eh == 8'd0) y = FP_ZERO;
    else if (hi[31] == lo[31]) y = sum[24] ? {hi[31], eh + 8'd1, sum[23:1]} : {hi[31], eh, sum[22:0]};
    else if (lz != 5'd24 && {3'b0, lz} < eh) y = {hi[31], eh - {3'b0, lz}, dn[22:0]};
  end
endmodule

// File: rtl/psum_accum_sched_rr_arbiter.sv
// rr_arbiter: N-way round-robin one-hot grant, search starting at ptr.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] idx;
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/psum_accum_sched.sv
// psum_accum_sched: round-robin lanes into one fp_adder over a row accumulator bank, drained on flush.
// Define PSUM_ZERO_SKIP_EN to drain only rows touched since the last start.
module psum_accum_sched
  import psum_accum_sched_pkg::*;
#(
  parameter int N          = 4,
  parameter int value_size = 32,
  parameter int ROWS       = 8,
  parameter int row_bits   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N-1:0]               req_valid,
  input  logic [N*value_size-1:0]    req_val,
  input  logic [N*row_bits-1:0]      req_row,
  output logic [N-1:0]               req_ready,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [row_bits-1:0]        out_row,
  output logic [value_size-1:0]      out_psum,
  output logic                       busy,
  output logic                       done
);
  localparam int PW = $clog2(N);
  state_e                state_q;
  logic [value_size-1:0] bank_q [ROWS];
  logic [PW-1:0]         ptr_q;
  logic [row_bits-1:0]   cnt_q;
  logic                  done_q;
  logic [N-1:0]          gnt;
  logic [PW-1:0]         g_idx;
  logic                  g_any;
  logic [row_bits-1:0]   g_row, sel;
  logic [value_size-1:0] g_val, sum;
  logic                  have, last;
  rr_arbiter #(.N(N)) u_arb (.req(req_valid), .ptr(ptr_q), .gnt(gnt));
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N; i++) if (gnt[i]) g_idx = PW'(i);
    g_any = state_q == ACCUM && |req_valid;
    g_row = req_row[g_idx*row_bits +: row_bits];
    g_val = req_val[g_idx*value_size +: value_size];
  end
  fp_adder u_add (.a(bank_q[g_row]), .b(g_val), .y(sum));
`ifdef PSUM_ZERO_SKIP_EN
  logic [ROWS-1:0] touched_q;
  // sel is the next touched row at or above the counter; untouched rows cost no cycles
  always_comb begin
    sel = cnt_q;
    have = 1'b0;
    last = 1'b1;
    for (int k = ROWS - 1; k >= 0; k--) if (touched_q[k] && k >= int'(cnt_q)) begin
      sel = row_bits'(k);
      have = 1'b1;
    end
    for (int k = 0; k < ROWS; k++) if (touched_q[k] && k > int'(sel)) last = 1'b0;
  end
`else
  assign sel  = cnt_q;
  assign have = 1'b1;
  assign last = 32'(cnt_q) == ROWS - 1;
`endif
  assign req_ready = state_q == ACCUM ? gnt : '0;
  assign out_valid = state_q == DRAIN && have;
  assign out_row   = out_valid ? sel : '0;
  assign out_psum  = out_valid ? bank_q[sel] : FP_ZERO;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (rst || start) begin
      state_q <= rst ? IDLE : ACCUM;
      ptr_q <= '0;
      cnt_q <= '0;
      for (int r = 0; r < ROWS; r++) bank_q[r] <= FP_ZERO;
`ifdef PSUM_ZERO_SKIP_EN
      touched_q <= '0;
`endif
    end else if (state_q == ACCUM) begin
      if (g_any) begin
        ptr_q <= PW'((int'(g_idx) + 1) % N);
        if (32'(g_row) < ROWS) begin
          bank_q[g_row] <= sum;
`ifdef PSUM_ZERO_SKIP_EN
          touched_q[g_row] <= 1'b1;
`endif
        end
      end
      if (flush) state_q <= DRAIN;
    end else if (state_q == DRAIN && (!have || out_ready)) begin
      if (!have || last) begin
        state_q <= IDLE;
        done_q <= 1'b1;
      end else cnt_q <= sel + 1'b1;
    end
  end
endmodule

// File: tb/tb_psum_accum_sched.sv
// tb_psum_accum_sched: directed + random checks against a row-sum model kept in quarter units.
module tb_psum_accum_sched;
  localparam int N = 4, VS = 32, ROWS = 8, RB = 3;
`ifdef PSUM_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*VS-1:0] req_val = '0;
  logic [N*RB-1:0] req_row = '0;
  logic [N-1:0] req_ready;
  logic out_valid, busy, done;
  logic [RB-1:0] out_row;
  logic [VS-1:0] out_psum;
  int total = 0, bad = 0;
  int q[ROWS];
  bit t[ROWS];
  int ptr;
  always #5 clk = ~clk;
  psum_accum_sched #(.N(N), .value_size(VS), .ROWS(ROWS), .row_bits(RB)) dut (
    .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_val(req_val),
    .req_row(req_row), .req_ready(req_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_psum(out_psum), .busy(busy), .done(done));
  // exact single-precision encoding of a non-negative multiple of 0.25
  function automatic logic [31:0] tofp(input int qv);
    int p;
    if (qv == 0) return 32'h0;
    p = $clog2(qv + 1) - 1;
    return {1'b0, 8'(p - 2 + 127), 23'((qv << (23 - p)) & 32'h7f_ffff)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) begin
      q[r] = 0;
      t[r] = 1'b0;
    end
    ptr = 0;
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    chk("start_busy", 32'(busy), 32'd1);
  endtask
  task automatic send(input logic [N-1:0] mask, input int rw[N], input int vl[N], input bit fl);
    int g;
    req_valid = mask;
    flush = fl;
    for (int i = 0; i < N; i++) begin
      req_val[i*VS +: VS] = tofp(vl[i]);
      req_row[i*RB +: RB] = RB'(rw[i]);
    end
    #1;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && mask[(ptr + k) % N]) g = (ptr + k) % N;
    chk("grant", 32'(req_ready), g < 0 ? 32'd0 : 32'd1 << g);
    if (g >= 0) begin
      q[rw[g]] += vl[g];
      t[rw[g]] = 1'b1;
      ptr = (g + 1) % N;
    end
    tick();
    req_valid = '0;
    flush = 1'b0;
  endtask
  task automatic send_rand(input int n);
    int rw[N], vl[N];
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        rw[i] = $urandom_range(0, ROWS - 1);
        vl[i] = $urandom_range(0, 400);
      end
      send(N'($urandom_range(0, 15)), rw, vl, 1'b0);
    end
  endtask
  task automatic drain(input int stall_pos, input int stall_n, input int stop_pos);
    int rows[$];
    for (int r = 0; r < ROWS; r++) if (!SKIP || t[r]) rows.push_back(r);
    if (rows.size() == 0) begin
      out_ready = 1'b1;
      #1;
      chk("empty_valid", 32'(out_valid), 32'd0);
      tick();
      out_ready = 1'b0;
      chk("empty_done", 32'(done), 32'd1);
      tick();
      chk("empty_done_low", 32'(done), 32'd0);
      return;
    end
    foreach (rows[p]) begin
      out_ready = 1'b0;
      if (p == stop_pos) begin
        #1;
        chk("stop_valid", 32'(out_valid), 32'd1);
        chk("stop_row", 32'(out_row), 32'(rows[p]));
        return;
      end
      for (int s = 0; s < (p == stall_pos ? stall_n : 0); s++) begin
        #1;
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_row", 32'(out_row), 32'(rows[p]));
        chk("stall_psum", out_psum, tofp(q[rows[p]]));
        chk("stall_done", 32'(done), 32'd0);
        tick();
      end
      out_ready = 1'b1;
      #1;
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_row", 32'(out_row), 32'(rows[p]));
      chk("drain_psum", out_psum, tofp(q[rows[p]]));
      tick();
    end
    out_ready = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    tick();
    chk("done_low", 32'(done), 32'd0);
  endtask
  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_row"}, 32'(out_row), 32'd0);
    chk({tag, "_psum"}, out_psum, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask
  initial begin
    int z[N] = '{0, 0, 0, 0};
    model_clear();
    repeat (3) tick();
    chk_zero_outputs("reset");
    rst = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_busy", 32'(busy), 32'd0);
    // lane 0: row 2 += 1.0 twice back to back
    do_start();
    send(4'b0001, '{2, 0, 0, 0}, '{4, 0, 0, 0}, 1'b0);
    send(4'b0001, '{2, 0, 0, 0}, '{4, 0, 0, 0}, 1'b0);
    chk("row2_model", tofp(q[2]), 32'h4000_0000);
    send(4'b0000, z, z, 1'b1);
    drain(-1, 0, -1);
    // all lanes to row 1 with 0.5, rotating grants; stall mid-drain
    do_start();
    repeat (8) send(4'b1111, '{1, 1, 1, 1}, '{2, 2, 2, 2}, 1'b0);
    chk("row1_model", tofp(q[1]), 32'h4080_0000);
    send(4'b0000, z, z, 1'b1);
    drain(SKIP ? 0 : 3, 3, -1);
    // flush together with a lane-3 accept
    do_start();
    send_rand(5);
    send(4'b1000, '{0, 0, 0, 5}, '{0, 0, 0, 12}, 1'b1);
    drain(-1, 0, -1);
    // random traffic
    do_start();
    send_rand(30);
    send(4'b0000, z, z, 1'b1);
    drain($urandom_range(0, 3), 2, -1);
    // start aborts a drain in progress
    do_start();
    send_rand(12);
    send(4'b0000, z, z, 1'b1);
    drain(-1, 0, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_valid", 32'(out_valid), 32'd0);
    send(4'b0000, z, z, 1'b1);
    drain(-1, 0, -1);
    // only rows 1 and 6 touched
    do_start();
    send(4'b0100, '{0, 0, 6, 0}, '{0, 0, 7, 0}, 1'b0);
    send(4'b0010, '{0, 1, 0, 0}, '{0, 9, 0, 0}, 1'b0);
    send(4'b0101, '{6, 0, 1, 0}, '{3, 0, 5, 0}, 1'b1);
    drain(-1, 0, -1);
    // reset mid-accumulate with requests still asserted
    do_start();
    send_rand(4);
    req_valid = 4'b1111;
    rst = 1'b1;
    tick();
    chk_zero_outputs("rst_mid");
    rst = 1'b0;
    req_valid = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
